// File: rtl/minute_core_pkg.sv
// Shared definitions for the minuteCore RV32I core: sizes, opcodes, funct3 codes,
// FSM states and the small combinational helpers used by the execute stage.
package minute_core_pkg;

  localparam int unsigned ADDR_SIZE  = 31;
  localparam int unsigned INSTR_SIZE = 31;
  localparam logic [ADDR_SIZE:0] RESET_PC = 32'h0000_0000;

  // Major opcodes (instruction bits [6:0])
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;

  // ALU funct3 codes (shared by OP and OP-IMM)
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch funct3 codes
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [0:0] {StFetch, StExec} state_e;

  // alt selects SUB for ADD and arithmetic shift for SR; ignored otherwise.
  function automatic logic [31:0] alu_op(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b, input logic alt);
    logic [31:0] r;
    case (f3)
      F3_ADD:  r = alt ? (a - b) : (a + b);
      F3_SLL:  r = a << b[4:0];
      F3_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      F3_SLTU: r = {31'b0, a < b};
      F3_XOR:  r = a ^ b;
      F3_SR:   r = alt ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      F3_OR:   r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic t;
    case (f3)
      F3_BEQ:  t = (a == b);
      F3_BNE:  t = (a != b);
      F3_BLT:  t = ($signed(a) < $signed(b));
      F3_BGE:  t = ($signed(a) >= $signed(b));
      F3_BLTU: t = (a < b);
      F3_BGEU: t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/minute_core_if.sv
// Instruction-memory read port: the core (master) requests, imem (slave) answers.
interface minute_core_if;
  import minute_core_pkg::*;

  logic [ADDR_SIZE:0]  imem_rd_addr;
  logic                imem_rd_enable;
  logic [INSTR_SIZE:0] imem_rd_data;
  logic                imem_rd_ready;

  modport master (
    output imem_rd_addr,
    output imem_rd_enable,
    input  imem_rd_data,
    input  imem_rd_ready
  );

  modport slave (
    input  imem_rd_addr,
    input  imem_rd_enable,
    output imem_rd_data,
    output imem_rd_ready
  );
endinterface

// File: rtl/minute_regfile.sv
// 32x32 integer register file: two asynchronous read ports, one synchronous write port.
// x0 is never written and always reads as zero.
module minute_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        we,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_data
);

  logic [31:0] regs [32];

  // Synchronous clear on reset; otherwise write rd unless it is x0
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (rd_addr != 5'd0)) begin
      regs[rd_addr] <= rd_data;
    end
  end

  // Asynchronous reads with x0 forced to zero
  always_comb begin
    rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];
    rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr];
  end

endmodule

// File: rtl/minute_core.sv
// Multicycle RV32I integer core: FETCH over the imem read port, then EXEC one instruction.
// Loads, stores, fences, system and illegal opcodes retire as NOPs.
module minute_core
  import minute_core_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  minute_core_if.master  imem
);

  state_e             state, state_d;
  logic [ADDR_SIZE:0] pc, pc_d;
  logic [31:0]        ir;
  // Low for the first cycle after reset so enable rises one cycle after release.
  logic               armed;

  logic        fetch_done;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rf_we;
  logic [31:0] rs1_data, rs2_data;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_b, imm_u, imm_j, pc_plus4;

  assign opcode   = ir[6:0];
  assign rd       = ir[11:7];
  assign funct3   = ir[14:12];
  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign imm_i    = {{20{ir[31]}}, ir[31:20]};
  assign imm_b    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u    = {ir[31:12], 12'b0};
  assign imm_j    = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign pc_plus4 = pc + 32'd4;

  assign fetch_done = imem.imem_rd_enable && imem.imem_rd_ready;

  minute_regfile minute_regfile (
    .clk      (clk),
    .reset    (reset),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (rf_we),
    .rd_addr  (rd),
    .rd_data  (wr_data)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= StFetch;
    end else begin
      state <= state_d;
    end
  end

  // FSM next state: leave FETCH only on an accepted read
  always_comb begin
    state_d = state;
    unique case (state)
      StFetch: if (fetch_done) state_d = StExec;
      StExec:  state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  // FSM outputs: read request and register write strobe
  always_comb begin
    imem.imem_rd_enable = (state == StFetch) && armed;
    imem.imem_rd_addr   = pc;
    rf_we               = (state == StExec) && wr_en;
  end

  // Datapath registers: pc, instruction register, fetch arming
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc    <= RESET_PC;
      ir    <= '0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (fetch_done) begin
        ir <= imem.imem_rd_data;
      end
      if (state == StExec) begin
        pc <= pc_d;
      end
    end
  end

  // Execute: result, write enable and next pc for the instruction in ir
  always_comb begin
    pc_d    = pc_plus4;
    wr_en   = 1'b0;
    wr_data = '0;
    case (opcode)
      OP_IMM: begin
        wr_en   = 1'b1;
        // Only SRAI uses bit 30; ADDI must never turn into a subtract.
        wr_data = alu_op(funct3, rs1_data, imm_i, (funct3 == F3_SR) && ir[30]);
      end
      OP: begin
        wr_en   = 1'b1;
        wr_data = alu_op(funct3, rs1_data, rs2_data, ir[30]);
      end
      LUI: begin
        wr_en   = 1'b1;
        wr_data = imm_u;
      end
      AUIPC: begin
        wr_en   = 1'b1;
        wr_data = pc + imm_u;
      end
      JAL: begin
        wr_en   = 1'b1;
        wr_data = pc_plus4;
        pc_d    = (pc + imm_j) & ~32'd3;
      end
      JALR: begin
        wr_en   = 1'b1;
        wr_data = pc_plus4;
        pc_d    = (rs1_data + imm_i) & ~32'd3;
      end
      BRANCH: begin
        if (branch_taken(funct3, rs1_data, rs2_data)) begin
          pc_d = (pc + imm_b) & ~32'd3;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_minute_core.sv
// Bench for minute_core: directed program, wait states, reset races and a random
// instruction stream checked against an ISA-level reference model.
module tb_minute_core;
  import minute_core_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  minute_core_if imem_bus ();

  minute_core dut (
    .clk   (clk),
    .reset (reset),
    .imem  (imem_bus)
  );

  logic [31:0] mem   [64];
  logic [31:0] mregs [32];
  logic [31:0] mpc;
  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Serve one fetch: wait for enable, insert wait states, then return the word.
  task automatic fetch_one(input int waits, output logic [31:0] addr, output bit ok,
                           output bit held);
    ok   = 1'b0;
    held = 1'b1;
    addr = '0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (imem_bus.imem_rd_enable === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    addr = imem_bus.imem_rd_addr;
    for (int w = 0; w < waits; w++) begin
      @(negedge clk);
      if (imem_bus.imem_rd_enable !== 1'b1 || imem_bus.imem_rd_addr !== addr) held = 1'b0;
    end
    imem_bus.imem_rd_data  = mem[addr[7:2]];
    imem_bus.imem_rd_ready = 1'b1;
    @(negedge clk);
    imem_bus.imem_rd_ready = 1'b0;
    imem_bus.imem_rd_data  = '0;
  endtask

  // Fetch plus the following execute edge; returns sampled just after that edge.
  task automatic run_instr(input int waits, output logic [31:0] addr, output bit ok,
                           output bit held);
    fetch_one(waits, addr, ok, held);
    if (ok) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ISA-level reference: one instruction applied to mregs/mpc.
  task automatic model_step(input logic [31:0] ins);
    logic [31:0] a, b, r, nxt, imm_i, imm_b, imm_u, imm_j;
    logic [4:0]  rd;
    logic [2:0]  f3;
    bit w;
    rd    = ins[11:7];
    f3    = ins[14:12];
    a     = mregs[ins[19:15]];
    b     = mregs[ins[24:20]];
    imm_i = $unsigned($signed(ins) >>> 20);
    imm_u = ins & 32'hFFFF_F000;
    imm_b = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    imm_j = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    nxt   = mpc + 4;
    w     = 1'b0;
    r     = '0;
    case (ins[6:0])
      7'h13, 7'h33: begin
        logic [31:0] op2;
        op2 = (ins[6:0] == 7'h13) ? imm_i : b;
        w   = 1'b1;
        case (f3)
          3'd0: r = (ins[6:0] == 7'h33 && ins[30]) ? a - op2 : a + op2;
          3'd1: r = a << op2[4:0];
          3'd2: r = ($signed(a) < $signed(op2)) ? 32'd1 : 32'd0;
          3'd3: r = (a < op2) ? 32'd1 : 32'd0;
          3'd4: r = a ^ op2;
          3'd5: r = ins[30] ? $unsigned($signed(a) >>> op2[4:0]) : a >> op2[4:0];
          3'd6: r = a | op2;
          default: r = a & op2;
        endcase
      end
      7'h37: begin w = 1'b1; r = imm_u; end
      7'h17: begin w = 1'b1; r = mpc + imm_u; end
      7'h6F: begin w = 1'b1; r = mpc + 4; nxt = (mpc + imm_j) & 32'hFFFF_FFFC; end
      7'h67: begin w = 1'b1; r = mpc + 4; nxt = (a + imm_i) & 32'hFFFF_FFFC; end
      7'h63: begin
        bit t;
        case (f3)
          3'd0: t = (a == b);
          3'd1: t = (a != b);
          3'd4: t = ($signed(a) < $signed(b));
          3'd5: t = ($signed(a) >= $signed(b));
          3'd6: t = (a < b);
          3'd7: t = (a >= b);
          default: t = 1'b0;
        endcase
        if (t) nxt = (mpc + imm_b) & 32'hFFFF_FFFC;
      end
      default: ;
    endcase
    if (w && rd != 5'd0) mregs[rd] = r;
    mpc = nxt;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] word;
    logic [6:0]  other [5];
    logic [2:0]  bf3   [6];
    int sel;
    other[0] = 7'h03; other[1] = 7'h23; other[2] = 7'h0F; other[3] = 7'h73; other[4] = 7'h7F;
    bf3[0] = 3'd0; bf3[1] = 3'd1; bf3[2] = 3'd4; bf3[3] = 3'd5; bf3[4] = 3'd6; bf3[5] = 3'd7;
    word = $urandom();
    sel  = $urandom_range(0, 9);
    case (sel)
      0, 1: begin
        word[6:0] = 7'h13;
        if (word[14:12] == 3'd1) word[31:25] = 7'd0;
        if (word[14:12] == 3'd5) word[31:25] = {1'b0, word[30], 5'd0};
      end
      2, 3: begin
        word[6:0]   = 7'h33;
        word[31:25] = (word[14:12] == 3'd0 || word[14:12] == 3'd5) ?
                      {1'b0, word[30], 5'd0} : 7'd0;
      end
      4: word[6:0] = 7'h37;
      5: word[6:0] = 7'h17;
      6: word[6:0] = 7'h6F;
      7: begin word[6:0] = 7'h67; word[14:12] = 3'd0; end
      8: begin word[6:0] = 7'h63; word[14:12] = bf3[$urandom_range(0, 5)]; end
      default: word[6:0] = other[$urandom_range(0, 4)];
    endcase
    return word;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    imem_bus.imem_rd_ready = 1'b0;
    imem_bus.imem_rd_data  = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (imem_bus.imem_rd_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_enable: got %b want 0", imem_bus.imem_rd_enable);
    end
    n_checks++;
    if (imem_bus.imem_rd_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_addr: got %h want 00000000", imem_bus.imem_rd_addr);
    end
    n_checks++;
    for (int i = 0; i < 32; i++) begin
      if (dut.minute_regfile.regs[i] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_regs: x%0d got %h want 00000000", i, dut.minute_regfile.regs[i]);
        break;
      end
    end
    // Release together with a ready that must be ignored (enable still low).
    reset = 1'b1;
    imem_bus.imem_rd_ready = 1'b1;
    imem_bus.imem_rd_data  = 32'h0090_0393;
    @(negedge clk);
    imem_bus.imem_rd_ready = 1'b0;
    imem_bus.imem_rd_data  = '0;
    n_checks++;
    if (imem_bus.imem_rd_enable !== 1'b1 || imem_bus.imem_rd_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL release_fetch: enable=%b addr=%h want enable=1 addr=00000000",
               imem_bus.imem_rd_enable, imem_bus.imem_rd_addr);
    end
    n_checks++;
    if (dut.state !== StFetch || dut.ir !== 32'h0) begin
      n_fail++;
      $display("FAIL ready_ignored: state=%0d ir=%h want state=FETCH ir=00000000",
               dut.state, dut.ir);
    end
  endtask

  task automatic test_directed();
    logic [31:0] exp_addr [6];
    int          reg_idx  [6];
    logic [31:0] reg_val  [6];
    logic [31:0] addr;
    bit ok, held;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
    mem[0]  = 32'h0050_0093;  // ADDI x1,x0,5
    mem[1]  = 32'h0010_8133;  // ADD x2,x1,x1
    mem[2]  = 32'h1234_51B7;  // LUI x3,0x12345
    mem[3]  = 32'h0070_0013;  // ADDI x0,x0,7
    mem[4]  = 32'h0000_0463;  // BEQ x0,x0,+8
    mem[5]  = 32'h0010_0113;  // ADDI x2,x0,1 (must be skipped)
    mem[6]  = 32'h0100_00EF;  // JAL x1,+16
    mem[10] = 32'h0550_0213;  // ADDI x4,x0,0x55
    exp_addr[0] = 32'h00; reg_idx[0] = 1; reg_val[0] = 32'd5;
    exp_addr[1] = 32'h04; reg_idx[1] = 2; reg_val[1] = 32'd10;
    exp_addr[2] = 32'h08; reg_idx[2] = 3; reg_val[2] = 32'h1234_5000;
    exp_addr[3] = 32'h0C; reg_idx[3] = 0; reg_val[3] = 32'd0;
    exp_addr[4] = 32'h10; reg_idx[4] = 2; reg_val[4] = 32'd10;
    exp_addr[5] = 32'h18; reg_idx[5] = 1; reg_val[5] = 32'h1C;
    for (int s = 0; s < 6; s++) begin
      run_instr(1, addr, ok, held);
      n_checks++;
      if (!ok || addr !== exp_addr[s]) begin
        n_fail++;
        $display("FAIL directed_addr[%0d]: got %h (ok=%0d) want %h", s, addr, ok, exp_addr[s]);
      end
      n_checks++;
      if (dut.minute_regfile.regs[reg_idx[s]] !== reg_val[s]) begin
        n_fail++;
        $display("FAIL directed_reg[%0d]: x%0d got %h want %h", s, reg_idx[s],
                 dut.minute_regfile.regs[reg_idx[s]], reg_val[s]);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] addr;
    bit ok, held;
    run_instr(5, addr, ok, held);
    n_checks++;
    if (!ok || addr !== 32'h28) begin
      n_fail++;
      $display("FAIL wait_addr: got %h (ok=%0d) want 00000028", addr, ok);
    end
    n_checks++;
    if (!held) begin
      n_fail++;
      $display("FAIL wait_hold: enable/addr changed during wait states, want held at 00000028");
    end
    n_checks++;
    if (dut.minute_regfile.regs[4] !== 32'h55) begin
      n_fail++;
      $display("FAIL wait_exec: x4 got %h want 00000055", dut.minute_regfile.regs[4]);
    end
    @(negedge clk);
    n_checks++;
    if (imem_bus.imem_rd_enable !== 1'b1 || imem_bus.imem_rd_addr !== 32'h2C) begin
      n_fail++;
      $display("FAIL wait_next: enable=%b addr=%h want enable=1 addr=0000002c",
               imem_bus.imem_rd_enable, imem_bus.imem_rd_addr);
    end
  endtask

  task automatic test_reset_mid_fetch();
    bit seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (imem_bus.imem_rd_enable === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    reset = 1'b0;
    imem_bus.imem_rd_ready = 1'b1;
    imem_bus.imem_rd_data  = 32'h0010_0293;  // ADDI x5,x0,1
    @(posedge clk);
    #1;
    n_checks++;
    if (!seen || imem_bus.imem_rd_addr !== 32'h0 || imem_bus.imem_rd_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL midfetch_port: seen=%0d addr=%h enable=%b want addr=00000000 enable=0",
               seen, imem_bus.imem_rd_addr, imem_bus.imem_rd_enable);
    end
    n_checks++;
    if (dut.state !== StFetch || dut.ir !== 32'h0) begin
      n_fail++;
      $display("FAIL midfetch_state: state=%0d ir=%h want FETCH/00000000", dut.state, dut.ir);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (dut.minute_regfile.regs[5] !== 32'h0 || dut.state !== StFetch) begin
      n_fail++;
      $display("FAIL midfetch_nowrite: x5=%h state=%0d want 00000000/FETCH",
               dut.minute_regfile.regs[5], dut.state);
    end
    @(negedge clk);
    imem_bus.imem_rd_ready = 1'b0;
    imem_bus.imem_rd_data  = '0;
  endtask

  task automatic test_random();
    logic [31:0] addr, ins;
    bit ok, held;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = gen_instr();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mpc = RESET_PC;
    for (int n = 0; n < 300; n++) begin
      run_instr($urandom_range(0, 3), addr, ok, held);
      n_checks++;
      if (!ok || !held || addr !== mpc) begin
        n_fail++;
        $display("FAIL random_fetch[%0d]: addr=%h ok=%0d held=%0d want addr=%h", n, addr, ok,
                 held, mpc);
        if (!ok) break;
      end
      ins = mem[mpc[7:2]];
      model_step(ins);
      n_checks++;
      for (int i = 0; i < 32; i++) begin
        if (dut.minute_regfile.regs[i] !== mregs[i]) begin
          n_fail++;
          $display("FAIL random_regs[%0d]: ins=%h x%0d got %h want %h", n, ins, i,
                   dut.minute_regfile.regs[i], mregs[i]);
          break;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_wait_states();
    test_reset_mid_fetch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
